// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared core widths, load/store encodings and MMIO map  (rev 1.1)
// ============================================================================
`default_nettype none

package riscv_pkg;

   localparam int XLEN = 32;
   localparam int ALEN = 32;

   localparam logic [2:0] F3_BYTE = 3'b000;
   localparam logic [2:0] F3_HALF = 3'b001;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_LHU  = 3'b101;

   localparam logic [3:0] MMIO_LED_OFF       = 4'h0;
   localparam logic [3:0] MMIO_UART_DATA_OFF = 4'h4;
   localparam logic [3:0] MMIO_UART_STAT_OFF = 4'h8;

   localparam int UART_STAT_BUSY_BIT  = 0;
   localparam int UART_STAT_FULL_BIT  = 1;
   localparam int UART_STAT_EMPTY_BIT = 2;
   localparam int UART_STAT_OVF_BIT   = 3;
   localparam int UART_STAT_CNT_LSB   = 8;

   typedef enum logic [1:0] {
      TX_IDLE      = 2'd0,
      TX_WAIT_BUSY = 2'd1,
      TX_WAIT_DONE = 2'd2
   } tx_state_t;

   // Align the addressed lane to bit 0, then sign/zero extend per access size.
   function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] word,
                                                input logic [1:0]      off,
                                                input logic [2:0]      f3);
      logic [XLEN-1:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         F3_BYTE: fmt_load = {{(XLEN-8){sh[7]}}, sh[7:0]};
         F3_LBU:  fmt_load = {{(XLEN-8){1'b0}}, sh[7:0]};
         F3_HALF: fmt_load = {{(XLEN-16){sh[15]}}, sh[15:0]};
         F3_LHU:  fmt_load = {{(XLEN-16){1'b0}}, sh[15:0]};
         default: fmt_load = sh;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO, first-word fall-through read   (rev 1.0)
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO still lands when the same cycle frees a slot.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : 8N1 serial transmitter, line idles high              (rev 1.0)
// ============================================================================
`default_nettype none

module uart_tx #(
   parameter int CLKS_PER_BIT = 68
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       busy_o,
   output logic       tx_o
);

   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      U_IDLE  = 2'd0,
      U_START = 2'd1,
      U_DATA  = 2'd2,
      U_STOP  = 2'd3
   } uart_state_t;

   uart_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          tick;

   assign tick   = (cnt_q == LAST);
   assign busy_o = (state_q != U_IDLE);
   // Line is decoded straight from state so reset returns it high at once.
   assign tx_o   = (state_q == U_START) ? 1'b0 :
                   (state_q == U_DATA)  ? sh_q[0] : 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      case (state_q)
         U_IDLE: begin
            if (start_i) begin
               sh_d    = data_i;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = U_START;
            end
         end
         U_START: begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick) state_d = U_DATA;
         end
         U_DATA: begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
               sh_d = sh_q >> 1;
               if (bit_q == 3'd7) state_d = U_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         U_STOP: begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick) state_d = U_IDLE;
         end
         default: state_d = U_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= U_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/data_memory_mmio.sv
// ============================================================================
// data_memory_mmio : MEM-stage byte-enabled RAM plus LED/UART MMIO   (rev 2.0)
// ============================================================================
`default_nettype none

module data_memory_mmio
   import riscv_pkg::*;
#(
   parameter int              DEPTH_WORDS       = 4096,
   parameter logic [ALEN-1:0] MMIO_BASE         = 32'h8000_0000,
   parameter int              NUM_LEDS          = 4,
   parameter int              UART_CLKS_PER_BIT = 68,
   parameter int              TX_FIFO_DEPTH     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                MemRead,
   input  logic                MemWrite,
   input  logic [3:0]          be,
   input  logic [2:0]          funct3,
   input  logic [ALEN-1:0]     Address,
   input  logic [XLEN-1:0]     WriteData,
   output logic [XLEN-1:0]     ReadData,
   output logic                fault,
   output logic [NUM_LEDS-1:0] leds_out,
   output logic                uart_tx_wire
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

   logic [XLEN-1:0] mem_q [DEPTH_WORDS];
   logic [XLEN-1:0] ram_rdata_q;

   logic                sel_ram_q, sel_ram_d;
   logic [XLEN-1:0]     mmio_rdata_q, mmio_rdata_d;
   logic [1:0]          off_q, off_d;
   logic [2:0]          f3_q, f3_d;
   logic                fault_q, fault_d;
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic                ovf_q, ovf_d;
   tx_state_t           state_q, state_d;
   logic                tx_start_q, tx_start_d;
   logic [7:0]          tx_byte_q, tx_byte_d;

   logic [1:0]      off;
   logic            misaligned, hit_ram, hit_led, hit_udata, hit_ustat, bad;
   logic            wr_ok, rd_ok, ram_we;
   logic [AW-1:0]   word_idx;
   logic [XLEN-1:0] wdata_sh, status;
   logic            fifo_push, fifo_pop, fifo_full, fifo_empty, uart_busy;
   logic [7:0]      fifo_rdata;
   logic [CW-1:0]   fifo_count;

   // ---------------------------------------------------------------- decode
   assign off        = Address[1:0];
   assign misaligned = (((funct3 == F3_HALF) || (funct3 == F3_LHU)) && Address[0]) ||
                       ((funct3 == F3_WORD) && (off != 2'b00));
   assign hit_ram    = (Address[ALEN-1:AW+2] == '0);
   assign hit_led    = (Address == MMIO_BASE + ALEN'(MMIO_LED_OFF));
   assign hit_udata  = (Address == MMIO_BASE + ALEN'(MMIO_UART_DATA_OFF));
   assign hit_ustat  = (Address == MMIO_BASE + ALEN'(MMIO_UART_STAT_OFF));
   assign bad        = (MemRead || MemWrite) &&
                       (misaligned || !(hit_ram || hit_led || hit_udata || hit_ustat));
   // A simultaneous read and write is treated as a write.
   assign wr_ok      = MemWrite && !bad;
   assign rd_ok      = MemRead && !MemWrite && !bad;
   assign ram_we     = wr_ok && hit_ram;
   assign fifo_push  = wr_ok && hit_udata;
   assign word_idx   = Address[AW+1:2];
   assign wdata_sh   = WriteData << {off, 3'b000};

   // ------------------------------------------------------------------- RAM
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_we && be[i]) begin
            mem_q[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
      if (rd_ok) begin
         ram_rdata_q <= mem_q[word_idx];
      end
   end

   // ------------------------------------------------- MMIO and read pipeline
   always_comb begin
      status                      = '0;
      status[UART_STAT_BUSY_BIT]  = uart_busy || (state_q != TX_IDLE);
      status[UART_STAT_FULL_BIT]  = fifo_full;
      status[UART_STAT_EMPTY_BIT] = fifo_empty;
      status[UART_STAT_OVF_BIT]   = ovf_q;
      status[UART_STAT_CNT_LSB +: 8] = 8'(fifo_count);
   end

   always_comb begin
      sel_ram_d    = sel_ram_q;
      mmio_rdata_d = mmio_rdata_q;
      off_d        = off_q;
      f3_d         = f3_q;
      fault_d      = bad;
      led_d        = led_q;
      ovf_d        = ovf_q;
      if (rd_ok) begin
         sel_ram_d    = hit_ram;
         off_d        = off;
         f3_d         = funct3;
         mmio_rdata_d = hit_led   ? XLEN'(led_q) :
                        hit_ustat ? status       : '0;
      end else if (bad) begin
         sel_ram_d    = 1'b0;
         mmio_rdata_d = '0;
      end
      if (wr_ok && hit_led) begin
         led_d = WriteData[NUM_LEDS-1:0];
      end
      if (wr_ok && hit_ustat && WriteData[UART_STAT_OVF_BIT]) begin
         ovf_d = 1'b0;
      end
      if (fifo_push && fifo_full && !fifo_pop) begin
         ovf_d = 1'b1;
      end
   end

   assign ReadData = fault_q ? '0 : fmt_load(sel_ram_q ? ram_rdata_q : mmio_rdata_q, off_q, f3_q);
   assign fault    = fault_q;
   assign leds_out = led_q;

   // ------------------------------------------------------------- drain FSM
   always_comb begin
      state_d    = state_q;
      fifo_pop   = 1'b0;
      tx_start_d = 1'b0;
      tx_byte_d  = tx_byte_q;
      case (state_q)
         TX_IDLE: begin
            if (!fifo_empty && !uart_busy) begin
               fifo_pop   = 1'b1;
               tx_byte_d  = fifo_rdata;
               tx_start_d = 1'b1;
               state_d    = TX_WAIT_BUSY;
            end
         end
         TX_WAIT_BUSY: if (uart_busy)  state_d = TX_WAIT_DONE;
         TX_WAIT_DONE: if (!uart_busy) state_d = TX_IDLE;
         default:      state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_ram_q    <= 1'b0;
         mmio_rdata_q <= '0;
         off_q        <= '0;
         f3_q         <= F3_WORD;
         fault_q      <= 1'b0;
         led_q        <= '0;
         ovf_q        <= 1'b0;
         state_q      <= TX_IDLE;
         tx_start_q   <= 1'b0;
         tx_byte_q    <= '0;
      end else begin
         sel_ram_q    <= sel_ram_d;
         mmio_rdata_q <= mmio_rdata_d;
         off_q        <= off_d;
         f3_q         <= f3_d;
         fault_q      <= fault_d;
         led_q        <= led_d;
         ovf_q        <= ovf_d;
         state_q      <= state_d;
         tx_start_q   <= tx_start_d;
         tx_byte_q    <= tx_byte_d;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (TX_FIFO_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .data_i  (WriteData[7:0]),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   uart_tx #(
      .CLKS_PER_BIT (UART_CLKS_PER_BIT)
   ) u_uart_tx (
      .clk     (clk),
      .rst     (rst),
      .start_i (tx_start_q),
      .data_i  (tx_byte_q),
      .busy_o  (uart_busy),
      .tx_o    (uart_tx_wire)
   );

endmodule

`default_nettype wire

// File: tb/tb_data_memory_mmio.sv
// ============================================================================
// tb_data_memory_mmio : randomized + directed checks against a byte-array model
// ============================================================================
`default_nettype none

module tb_data_memory_mmio;
   import riscv_pkg::*;

   localparam int          CPB  = 8;
   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int          REGION = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [3:0]  be = '0;
   logic [2:0]  funct3 = F3_WORD;
   logic [31:0] Address = '0, WriteData = '0;
   logic [31:0] ReadData;
   logic        fault;
   logic [3:0]  leds_out;
   logic        uart_tx_wire;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] ref_mem [0:REGION-1];
   logic [7:0] rx_q [$];
   logic [7:0] rx_byte;

   data_memory_mmio #(
      .DEPTH_WORDS       (1024),
      .MMIO_BASE         (BASE),
      .NUM_LEDS          (4),
      .UART_CLKS_PER_BIT (CPB),
      .TX_FIFO_DEPTH     (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .be           (be),
      .funct3       (funct3),
      .Address      (Address),
      .WriteData    (WriteData),
      .ReadData     (ReadData),
      .fault        (fault),
      .leds_out     (leds_out),
      .uart_tx_wire (uart_tx_wire)
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1, "watchdog");
   end

   // Serial decoder: samples mid-bit after each falling edge.
   initial begin
      forever begin
         @(negedge uart_tx_wire);
         if (!rst) begin
            repeat (CPB/2) @(posedge clk);
            for (int b = 0; b < 8; b++) begin
               repeat (CPB) @(posedge clk);
               rx_byte[b] = uart_tx_wire;
            end
            repeat (CPB) @(posedge clk);
            rx_q.push_back(rx_byte);
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic mem_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic flt);
      @(negedge clk);
      MemRead = rd; MemWrite = wr; funct3 = f3; Address = addr; WriteData = wdata;
      case (f3)
         F3_HALF, F3_LHU: be = 4'b0011 << addr[1:0];
         F3_WORD:         be = 4'b1111;
         default:         be = 4'b0001 << addr[1:0];
      endcase
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      rdata = ReadData;
      flt   = fault;
   endtask

   function automatic logic model_misaligned(input logic [2:0] f3, input int a);
      if (f3 == F3_WORD) return (a % 4) != 0;
      if (f3 == F3_HALF || f3 == F3_LHU) return (a % 2) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
      logic [15:0] h;
      if (model_misaligned(f3, a)) return 32'h0;
      h = {ref_mem[a+1], ref_mem[a]};
      case (f3)
         F3_BYTE: return {{24{ref_mem[a][7]}}, ref_mem[a]};
         F3_LBU:  return {24'h0, ref_mem[a]};
         F3_HALF: return {{16{h[15]}}, h};
         F3_LHU:  return {16'h0, h};
         default: return {ref_mem[a+3], ref_mem[a+2], h};
      endcase
   endfunction

   task automatic ram_store(input logic [2:0] f3, input int a, input logic [31:0] data);
      logic [31:0] rd;
      logic        f, exp_f;
      int          n;
      mem_op(1'b0, 1'b1, f3, a, data, rd, f);
      exp_f = model_misaligned(f3, a);
      check_eq("st_fault", f, exp_f);
      if (!exp_f) begin
         n = (f3 == F3_WORD) ? 4 : (f3 == F3_HALF) ? 2 : 1;
         for (int k = 0; k < n; k++) ref_mem[a+k] = data[8*k +: 8];
      end
   endtask

   task automatic ram_load(input logic [2:0] f3, input int a);
      logic [31:0] rd;
      logic        f;
      mem_op(1'b1, 1'b0, f3, a, 32'h0, rd, f);
      check_eq($sformatf("ld_data f3=%0d a=0x%0h", f3, a), rd, model_load(f3, a));
      check_eq("ld_fault", f, model_misaligned(f3, a));
   endtask

   initial begin
      logic [31:0] rd;
      logic        f, done;
      logic [2:0]  f3s [5];
      logic [2:0]  f3;
      int          a, n;
      f3s = '{F3_BYTE, F3_HALF, F3_WORD, F3_LBU, F3_LHU};

      repeat (3) @(negedge clk);
      check_eq("rst_tx_in_reset", uart_tx_wire, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_readdata", ReadData, 32'h0);
      check_eq("rst_fault", fault, 1'b0);
      check_eq("rst_leds", leds_out, 4'h0);
      check_eq("rst_tx", uart_tx_wire, 1'b1);

      for (int w = 0; w < REGION/4; w++) ram_store(F3_WORD, w*4, $urandom);

      // Sub-word loads with sign/zero extension
      ram_store(F3_WORD, 32'h100, 32'hDEAD_BEEF);
      mem_op(1'b1, 1'b0, F3_BYTE, 32'h101, 0, rd, f); check_eq("lb_101",  rd, 32'hFFFF_FFBE);
      mem_op(1'b1, 1'b0, F3_LBU,  32'h101, 0, rd, f); check_eq("lbu_101", rd, 32'h0000_00BE);
      mem_op(1'b1, 1'b0, F3_HALF, 32'h102, 0, rd, f); check_eq("lh_102",  rd, 32'hFFFF_DEAD);
      mem_op(1'b1, 1'b0, F3_LHU,  32'h102, 0, rd, f); check_eq("lhu_102", rd, 32'h0000_DEAD);

      ram_store(F3_WORD, 32'h200, 32'h1122_3344);
      ram_store(F3_BYTE, 32'h203, 32'h0000_005A);
      mem_op(1'b1, 1'b0, F3_WORD, 32'h200, 0, rd, f); check_eq("sb_merge", rd, 32'h5A22_3344);

      // LED register
      mem_op(1'b0, 1'b1, F3_WORD, BASE, 32'hF, rd, f);
      check_eq("leds_set", leds_out, 4'hF);
      mem_op(1'b1, 1'b0, F3_WORD, BASE, 0, rd, f); check_eq("led_readback", rd, 32'h0000_000F);

      // Faults
      mem_op(1'b1, 1'b0, F3_WORD, 32'h102, 0, rd, f);
      check_eq("lw_mis_fault", f, 1'b1); check_eq("lw_mis_data", rd, 32'h0);
      @(negedge clk); check_eq("fault_pulse_end", fault, 1'b0);
      mem_op(1'b1, 1'b0, F3_HALF, 32'h101, 0, rd, f); check_eq("lh_mis_fault", f, 1'b1);
      mem_op(1'b0, 1'b1, F3_WORD, 32'h102, 32'hFFFF_FFFF, rd, f); check_eq("sw_mis_fault", f, 1'b1);
      mem_op(1'b1, 1'b0, F3_WORD, 32'h100, 0, rd, f); check_eq("ram_unchanged", rd, 32'hDEAD_BEEF);
      mem_op(1'b1, 1'b0, F3_WORD, 32'h9000_0000, 0, rd, f);
      check_eq("unmapped_fault", f, 1'b1); check_eq("unmapped_data", rd, 32'h0);
      mem_op(1'b0, 1'b1, F3_WORD, 32'h1000, 32'h1234_5678, rd, f); check_eq("oor_store_fault", f, 1'b1);
      mem_op(1'b0, 1'b1, F3_BYTE, 32'h0FFF, 32'h0000_00C3, rd, f); check_eq("top_byte_fault", f, 1'b0);
      mem_op(1'b1, 1'b0, F3_LBU, 32'h0FFF, 0, rd, f); check_eq("top_byte_data", rd, 32'h0000_00C3);

      // Randomized RAM traffic
      for (int t = 0; t < 200; t++) begin
         f3 = f3s[$urandom_range(0, 4)];
         a  = $urandom_range(0, REGION - 4);
         if ($urandom_range(0, 1) == 0) ram_store(f3 & 3'b011, a, $urandom);
         else                           ram_load(f3, a);
      end

      // UART: ten back-to-back byte stores into an 8-deep FIFO
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         MemWrite = 1'b1; funct3 = F3_BYTE; Address = BASE + 32'h4;
         WriteData = 32'h41 + i; be = 4'b0001;
      end
      @(negedge clk); MemWrite = 1'b0;
      mem_op(1'b1, 1'b0, F3_WORD, BASE + 32'h8, 0, rd, f); check_eq("ovf_set", rd[3], 1'b1);
      mem_op(1'b0, 1'b1, F3_WORD, BASE + 32'h8, 32'h8, rd, f);
      mem_op(1'b1, 1'b0, F3_WORD, BASE + 32'h8, 0, rd, f); check_eq("ovf_cleared", rd[3], 1'b0);
      done = 1'b0;
      for (int i = 0; i < 5000 && !done; i++) begin
         mem_op(1'b1, 1'b0, F3_WORD, BASE + 32'h8, 0, rd, f);
         if (rd[2] && !rd[0]) done = 1'b1;
      end
      check_eq("drain_done", done, 1'b1);
      check_eq("stat_drained", rd, 32'h0000_0004);
      repeat (4*CPB) @(posedge clk);
      n = rx_q.size();
      check_eq("rx_count_in_range", (n >= 8 && n <= 10), 1'b1);
      for (int i = 0; i < n; i++) check_eq($sformatf("rx_byte%0d", i), rx_q[i], 32'h41 + i);

      // Reset in the middle of a frame of all-zero data bits
      mem_op(1'b0, 1'b1, F3_WORD, BASE, 32'h5, rd, f);
      mem_op(1'b0, 1'b1, F3_BYTE, BASE + 32'h4, 32'h0, rd, f);
      repeat (3*CPB) @(posedge clk);
      #1 check_eq("tx_midframe_low", uart_tx_wire, 1'b0);
      check_eq("leds_before_rst", leds_out, 4'h5);
      #2 rst = 1'b1;
      #1 check_eq("rst_tx_idle", uart_tx_wire, 1'b1);
      check_eq("rst_leds_clear", leds_out, 4'h0);
      check_eq("rst_rdata_clear", ReadData, 32'h0);
      @(negedge clk); rst = 1'b0;
      mem_op(1'b1, 1'b0, F3_WORD, BASE + 32'h8, 0, rd, f);
      check_eq("stat_after_rst", rd, 32'h0000_0004);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
